raw_frame_gen: RTL and testbench

- Transmit-side source for the raw pixel stream interface that the image pipeline consumes: 12-bit pixel data, data-valid strobe, and 16-bit column/row counts.
- Generates full frames with active, horizontal-blank and vertical-blank periods. Each frame carries a selectable synthetic Bayer-domain pattern.
- Used in place of the camera capture stage for bring-up and regression of the grayscale/buffer/convolution chain.

---
 rtl/raw_frame_gen_pkg.sv | 17 +
 rtl/frame_timing.sv | 100 ++++++++++
 rtl/raw_frame_gen.sv | 80 ++++++++
 tb/tb_raw_frame_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/raw_frame_gen_pkg.sv
// raw_frame_gen_pkg: shared states, pattern codes and LFSR constants for the raw frame generator.
package raw_frame_gen_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} stateT;

    localparam logic [1:0]  PAT_HRAMP   = 2'd0;
    localparam logic [1:0]  PAT_VRAMP   = 2'd1;
    localparam logic [1:0]  PAT_CHECKER = 2'd2;
    localparam logic [1:0]  PAT_CONST   = 2'd3;
    localparam logic [11:0] CONST_LEVEL = 12'h800;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions of a right-shifting register.
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction
endpackage

// File: rtl/frame_timing.sv
// frame_timing: frame FSM with column/row/blank counters, stop flag and completed-frame count.
module frame_timing
    import raw_frame_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    output logic        active,
    output logic        frameStart,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        busy,
    output logic [31:0] frameCount
);
    localparam int VB_LEN  = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int CNT_MAX = VB_LEN > H_BLANK ? VB_LEN : H_BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [15:0]   X_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0]   Y_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VB_LAST = CW'(VB_LEN - 1);

    stateT         state, stateD;
    logic [15:0]   xQ, yQ;
    logic [CW-1:0] cnt, cntD;
    logic          stop, stopD, frameDone;

    // x/y/active are the values the next cycle will show, so the top can register its outputs.
    always_comb begin
        stateD     = state;
        x          = xQ;
        y          = yQ;
        cntD       = cnt;
        stopD      = stop | (state != IDLE && iSTOP);
        frameStart = 1'b0;
        frameDone  = 1'b0;
        case (state)
            IDLE: if (iSTART) begin
                stateD     = ACTIVE;
                x          = '0;
                y          = '0;
                frameStart = 1'b1;
                stopD      = iSTOP;
            end
            ACTIVE: if (xQ == X_LAST) begin
                stateD = HBLANK;
                cntD   = '0;
            end else x = xQ + 16'd1;
            HBLANK: if (cnt == HB_LAST) begin
                cntD = '0;
                if (yQ == Y_LAST) stateD = VBLANK;
                else begin
                    stateD = ACTIVE;
                    x      = '0;
                    y      = yQ + 16'd1;
                end
            end else cntD = cnt + CW'(1);
            VBLANK: if (cnt == VB_LAST) begin
                frameDone = 1'b1;
                if (stopD) begin
                    stateD = IDLE;
                    stopD  = 1'b0;
                end else begin
                    stateD     = ACTIVE;
                    x          = '0;
                    y          = '0;
                    frameStart = 1'b1;
                end
            end else cntD = cnt + CW'(1);
            default: stateD = IDLE;
        endcase
        active = stateD == ACTIVE;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            xQ         <= '0;
            yQ         <= '0;
            cnt        <= '0;
            stop       <= 1'b0;
            busy       <= 1'b0;
            frameCount <= '0;
        end else begin
            state      <= stateD;
            xQ         <= x;
            yQ         <= y;
            cnt        <= cntD;
            stop       <= stopD;
            busy       <= stateD != IDLE;
            frameCount <= frameCount + {31'd0, frameDone};
        end
    end
endmodule

// File: rtl/raw_frame_gen.sv
// raw_frame_gen: synthetic raw Bayer-domain frame source with selectable test patterns.
// Define RAW_FRAME_GEN_LFSR_EN to make pattern 3 a pseudo-random LFSR stream instead of a constant.
module raw_frame_gen
    import raw_frame_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iPATTERN,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);
    logic        active, frameStart;
    logic [15:0] x, y;
    logic [1:0]  pat, patD;
    logic [11:0] constPix, pix;

    frame_timing #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK)
    ) uTiming (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iSTART    (iSTART),
        .iSTOP     (iSTOP),
        .active    (active),
        .frameStart(frameStart),
        .x         (x),
        .y         (y),
        .busy      (oBUSY),
        .frameCount(oFrame_Cont)
    );

    assign patD = frameStart ? iPATTERN : pat;

`ifdef RAW_FRAME_GEN_LFSR_EN
    logic [15:0] lfsr, lfsrCur;
    // The first pixel of every frame uses the seed itself.
    assign lfsrCur  = frameStart ? LFSR_SEED : lfsr;
    assign constPix = lfsrCur[11:0];
    always_ff @(posedge iCLK) begin
        if (iRST) lfsr <= LFSR_SEED;
        else if (active) lfsr <= lfsrStep(lfsrCur);
    end
`else
    assign constPix = CONST_LEVEL;
`endif

    always_comb pix = patD == PAT_HRAMP   ? x[11:0] :
                      patD == PAT_VRAMP   ? y[11:0] :
                      patD == PAT_CHECKER ? {12{x[3] ^ y[3]}} : constPix;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pat     <= PAT_HRAMP;
            oDATA   <= '0;
            oDVAL   <= 1'b0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else begin
            pat     <= patD;
            oDATA   <= active ? pix : '0;
            oDVAL   <= active;
            oX_Cont <= x;
            oY_Cont <= y;
        end
    end
endmodule

// File: tb/tb_raw_frame_gen.sv
// tb_raw_frame_gen: directed checks of frame timing, stop/start handling and patterns on two geometries.
module tb_raw_frame_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, startA, stopA, dvalA, busyA;
    logic [1:0]  patA;
    logic [11:0] dataA;
    logic [15:0] xA, yA;
    logic [31:0] frameA;
    logic        rstB, startB, stopB, dvalB, busyB;
    logic [1:0]  patB;
    logic [11:0] dataB;
    logic [15:0] xB, yB;
    logic [31:0] frameB;

    raw_frame_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_BLANK(1)) dutA (
        .iCLK(clk), .iRST(rstA), .iSTART(startA), .iSTOP(stopA), .iPATTERN(patA),
        .oDATA(dataA), .oDVAL(dvalA), .oX_Cont(xA), .oY_Cont(yA),
        .oFrame_Cont(frameA), .oBUSY(busyA)
    );

    raw_frame_gen #(.H_ACTIVE(16), .V_ACTIVE(16), .H_BLANK(2), .V_BLANK(1)) dutB (
        .iCLK(clk), .iRST(rstB), .iSTART(startB), .iSTOP(stopB), .iPATTERN(patB),
        .oDATA(dataB), .oDVAL(dvalB), .oX_Cont(xB), .oY_Cont(yB),
        .oFrame_Cont(frameB), .oBUSY(busyB)
    );

    int checks = 0;
    int failures = 0;
    int cycB;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetA();
        rstA = 1'b1;
        step(1);
        rstA = 1'b0;
    endtask

    task automatic gotoB(input int target);
        step(target - cycB);
        cycB = target;
    endtask

    logic [11:0] lfsrExp [3];
    logic        v;
    int          px, py, cnt, n;

    initial begin
`ifdef RAW_FRAME_GEN_LFSR_EN
        lfsrExp = '{12'hCE1, 12'h670, 12'hB38};
`else
        lfsrExp = '{12'h800, 12'h800, 12'h800};
`endif
        rstA = 1'b1; startA = 1'b0; stopA = 1'b0; patA = 2'd0;
        rstB = 1'b1; startB = 1'b0; stopB = 1'b0; patB = 2'd0;
        step(2);
        rstA = 1'b0;
        rstB = 1'b0;
        check("rst_dval", dvalA, 1'b0);
        check("rst_x", xA, 16'd0);
        check("rst_y", yA, 16'd0);
        check("rst_data", dataA, 12'd0);
        check("rst_frame", frameA, 32'd0);
        check("rst_busy", busyA, 1'b0);

        // Free-running horizontal ramp; one full frame cycle by cycle.
        startA = 1'b1;
        step(1);
        startA = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            px = (c - 1) % 6;
            py = (c - 1) / 6;
            v  = c <= 18 && px < 4;
            check("t1_dval", dvalA, v);
            if (v) begin
                check("t1_x", xA, px);
                check("t1_y", yA, py);
                check("t1_data", dataA, px);
            end else begin
                check("t1_blank_data", dataA, 12'd0);
                check("t1_blank_x", xA, 16'd3);
            end
            check("t1_busy", busyA, 1'b1);
            if (c < 24) step(1);
        end
        check("t1_frame_c24", frameA, 32'd0);
        step(1);
        check("t1_frame_c25", frameA, 32'd1);
        check("t1_dval_c25", dvalA, 1'b1);
        check("t1_x_c25", xA, 16'd0);
        check("t1_y_c25", yA, 16'd0);
        stopA = 1'b1;
        step(1);
        stopA = 1'b0;
        n = 0;
        while (busyA && n < 60) begin
            step(1);
            n++;
        end
        check("t1_stop_idle", busyA, 1'b0);
        check("t1_frame_end", frameA, 32'd2);

        // Single shot: start and stop together.
        resetA();
        startA = 1'b1;
        stopA  = 1'b1;
        step(1);
        startA = 1'b0;
        stopA  = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 24; c++) begin
            cnt += int'(dvalA);
            if (c < 24) step(1);
        end
        check("t2_busy_c24", busyA, 1'b1);
        step(1);
        check("t2_busy_c25", busyA, 1'b0);
        check("t2_pixels", cnt, 12);
        check("t2_frame", frameA, 32'd1);

        // Stop pulse mid-frame, then a stop pulse in idle.
        resetA();
        startA = 1'b1;
        step(1);
        startA = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            cnt += int'(dvalA);
            if (c == 24) check("t3_busy_c24", busyA, 1'b1);
            if (c == 25) check("t3_busy_c25", busyA, 1'b0);
            stopA = c == 7;
            step(1);
        end
        stopA = 1'b0;
        check("t3_pixels", cnt, 12);
        check("t3_frame", frameA, 32'd1);
        stopA = 1'b1;
        step(1);
        stopA = 1'b0;
        step(3);
        check("t3_idle_busy", busyA, 1'b0);
        check("t3_idle_dval", dvalA, 1'b0);
        check("t3_idle_frame", frameA, 32'd1);

        // Checkerboard on 16x16, with a pattern change mid-frame.
        patB   = 2'd2;
        startB = 1'b1;
        step(1);
        startB = 1'b0;
        cycB = 1;
        gotoB(8);
        check("t4_x_7_0", xB, 16'd7);
        check("t4_px_7_0", dataB, 12'h000);
        gotoB(9);
        check("t4_px_8_0", dataB, 12'hFFF);
        patB = 2'd1;
        gotoB(145);
        check("t4_px_0_8", dataB, 12'hFFF);
        gotoB(153);
        check("t4_px_8_8", dataB, 12'h000);
        gotoB(348);
        check("t4_f2_y", yB, 16'd2);
        check("t4_f2_px_5_2", dataB, 12'h002);
        gotoB(357);
        check("t4_f2_px_14_2", dataB, 12'h002);
        rstB = 1'b1;
        step(1);
        rstB = 1'b0;

        // Reset mid-line, then restart.
        resetA();
        startA = 1'b1;
        step(1);
        startA = 1'b0;
        step(7);
        check("t5_x_c8", xA, 16'd1);
        check("t5_y_c8", yA, 16'd1);
        rstA = 1'b1;
        step(1);
        rstA = 1'b0;
        check("t5_rst_dval", dvalA, 1'b0);
        check("t5_rst_x", xA, 16'd0);
        check("t5_rst_y", yA, 16'd0);
        check("t5_rst_data", dataA, 12'd0);
        check("t5_rst_busy", busyA, 1'b0);
        check("t5_rst_frame", frameA, 32'd0);
        step(2);
        check("t5_stays_idle", busyA, 1'b0);
        startA = 1'b1;
        step(1);
        startA = 1'b0;
        check("t5_restart_dval", dvalA, 1'b1);
        check("t5_restart_x", xA, 16'd0);
        check("t5_restart_y", yA, 16'd0);
        step(1);
        check("t5_restart_data1", dataA, 12'd1);

        // Pattern 3: constant level or LFSR stream depending on build.
        resetA();
        patA   = 2'd3;
        startA = 1'b1;
        step(1);
        startA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_pat3_px", dataA, lfsrExp[i]);
            step(1);
        end
        check("t6_pat3_px3_dval", dvalA, 1'b1);
        step(1);
        check("t6_blank_dval", dvalA, 1'b0);
        check("t6_blank_data", dataA, 12'd0);
        stopA = 1'b1;
        step(1);
        stopA = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
